// File: rtl/iomem_copy_master_pkg.sv
// Shared definitions for the iomem copy master: strobe encodings, FSM states and
// the address-step helper.
package iomem_copy_master_pkg;

  localparam logic [3:0] WSTRB_READ = 4'h0;
  localparam logic [3:0] WSTRB_WORD = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_RGAP = 3'd2,
    ST_WR   = 3'd3,
    ST_WGAP = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  // Fixed FIFO ports keep their address; memory-like ports advance one word.
  function automatic logic [31:0] addr_step(input logic [31:0] a, input bit inc);
    return inc ? a + 32'd4 : a;
  endfunction

endpackage

// File: rtl/iomem_watchdog.sv
// Per-transaction wait watchdog: cleared while load is high, counts cycles with
// count high, and flags expire on the LIMIT-th counted cycle.
module iomem_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic count,
  output logic expire
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire = count && (cnt_q == CW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = '0;
    else if (count && !expire)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/iomem_copy_master.sv
// Second iomem initiator that copies cmd_len words from src to dst, one read then
// one write per word. Define IOMEM_TIMEOUT_EN to abort on a responder that stalls.
module iomem_copy_master
  import iomem_copy_master_pkg::*;
#(
  parameter bit SRC_INC        = 1'b1,
  parameter bit DST_INC        = 1'b1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_src,
  input  logic [31:0] cmd_dst,
  input  logic [15:0] cmd_len,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata
);

  state_e      state_q, state_d;
  logic [31:0] src_q, src_d, dst_q, dst_d;
  logic [15:0] len_q, len_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] addr_q, addr_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        expire;

`ifdef IOMEM_TIMEOUT_EN
  iomem_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .load   (!valid_q),
    .count  (valid_q && !iomem_ready),
    .expire (expire)
  );
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign expire = 1'b0;
`endif

  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign iomem_valid = valid_q;
  assign iomem_wstrb = wstrb_q;
  assign iomem_addr  = addr_q;
  assign iomem_wdata = data_q;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    data_d  = data_q;
    valid_d = valid_q;
    wstrb_d = wstrb_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          src_d = cmd_src;
          dst_d = cmd_dst;
          len_d = cmd_len;
          err_d = 1'b0;
          if (cmd_len == 16'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RD;
            valid_d = 1'b1;
            wstrb_d = WSTRB_READ;
            addr_d  = cmd_src;
          end
        end
      end
      ST_RD: begin
        if (iomem_ready) begin
          data_d  = iomem_rdata;
          valid_d = 1'b0;
          state_d = ST_RGAP;
        end else if (expire) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_RGAP: begin
        valid_d = 1'b1;
        wstrb_d = WSTRB_WORD;
        addr_d  = dst_q;
        state_d = ST_WR;
      end
      ST_WR: begin
        if (iomem_ready) begin
          valid_d = 1'b0;
          len_d   = len_q - 16'd1;
          src_d   = addr_step(src_q, SRC_INC);
          dst_d   = addr_step(dst_q, DST_INC);
          state_d = ST_WGAP;
        end else if (expire) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_WGAP: begin
        if (len_q == 16'd0) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          valid_d = 1'b1;
          wstrb_d = WSTRB_READ;
          addr_d  = src_q;
          state_d = ST_RD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      wstrb_q <= WSTRB_READ;
      addr_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      wstrb_q <= wstrb_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_iomem_copy_master.sv
// Directed bench: dut0 uses incrementing addresses, dut1 a fixed source port.
// Both share one clock/reset; a per-DUT responder returns rdata = ~addr after dly cycles.
module tb_iomem_copy_master;

  typedef struct packed {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
  } txn_t;

  logic        clk, reset;
  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic [31:0] cmd_src   [2];
  logic [31:0] cmd_dst   [2];
  logic [15:0] cmd_len   [2];
  logic        busy      [2];
  logic        done      [2];
  logic        err       [2];
  logic        iv        [2];
  logic        ir        [2];
  logic [3:0]  wstrb     [2];
  logic [31:0] addr      [2];
  logic [31:0] wdata     [2];
  logic [31:0] rdata     [2];

  int   dly [2];
  int   wcnt[2];
  int   vcyc[2];
  bit   saw_v[2];
  bit   unstable[2];
  logic prev_v[2], prev_hs[2];
  logic [31:0] prev_a[2], prev_d[2];
  logic [3:0]  prev_w[2];
  txn_t q0[$], q1[$];

  int total = 0;
  int bad   = 0;

  iomem_copy_master #(.TIMEOUT_CYCLES(8)) dut0 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_src(cmd_src[0]), .cmd_dst(cmd_dst[0]), .cmd_len(cmd_len[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0]),
    .iomem_valid(iv[0]), .iomem_ready(ir[0]), .iomem_wstrb(wstrb[0]),
    .iomem_addr(addr[0]), .iomem_wdata(wdata[0]), .iomem_rdata(rdata[0])
  );

  iomem_copy_master #(.SRC_INC(1'b0), .TIMEOUT_CYCLES(8)) dut1 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_src(cmd_src[1]), .cmd_dst(cmd_dst[1]), .cmd_len(cmd_len[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1]),
    .iomem_valid(iv[1]), .iomem_ready(ir[1]), .iomem_wstrb(wstrb[1]),
    .iomem_addr(addr[1]), .iomem_wdata(wdata[1]), .iomem_rdata(rdata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rdata[0] = ~addr[0];
  assign rdata[1] = ~addr[1];

  // Responder: raise ready on the negedge once valid has waited dly cycles.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (iv[g]) begin
        if (wcnt[g] >= dly[g]) ir[g] = 1'b1;
        else begin ir[g] = 1'b0; wcnt[g]++; end
      end else begin
        ir[g]   = 1'b0;
        wcnt[g] = 0;
      end
    end
  end

  // Bus monitor: logs handshakes, counts valid cycles, flags unstable requests.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (prev_v[g] && !prev_hs[g] && iv[g] &&
          (addr[g] != prev_a[g] || wstrb[g] != prev_w[g] ||
           (wstrb[g] == 4'hF && wdata[g] != prev_d[g])))
        unstable[g] = 1'b1;
      if (iv[g]) begin
        vcyc[g]++;
        saw_v[g] = 1'b1;
        if (ir[g]) begin
          if (g == 0) q0.push_back({wstrb[g] == 4'hF, addr[g], (wstrb[g] == 4'hF) ? wdata[g] : rdata[g]});
          else        q1.push_back({wstrb[g] == 4'hF, addr[g], (wstrb[g] == 4'hF) ? wdata[g] : rdata[g]});
        end
      end
      prev_v[g]  = iv[g];
      prev_hs[g] = iv[g] && ir[g];
      prev_a[g]  = addr[g];
      prev_w[g]  = wstrb[g];
      prev_d[g]  = wdata[g];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon(input int idx);
    vcyc[idx] = 0; saw_v[idx] = 1'b0; unstable[idx] = 1'b0;
    if (idx == 0) q0.delete(); else q1.delete();
  endtask

  // Issue a command and return the negedge count (accept edge -> done seen).
  task automatic issue(input int idx, input logic [31:0] s, input logic [31:0] d,
                       input logic [15:0] n, output int k, output logic b1);
    @(negedge clk);
    cmd_src[idx] = s; cmd_dst[idx] = d; cmd_len[idx] = n; cmd_valid[idx] = 1'b1;
    @(posedge clk);
    k = 0; b1 = 1'b0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin b1 = busy[idx]; cmd_valid[idx] = 1'b0; end
    end while (!done[idx] && k < 2000);
  endtask

  initial begin
    int k;
    logic b1;
    bit found;
    bit saw_done;
    logic [31:0] a;
    for (int g = 0; g < 2; g++) begin
      cmd_valid[g] = 1'b0; cmd_src[g] = '0; cmd_dst[g] = '0; cmd_len[g] = '0;
      dly[g] = 0; wcnt[g] = 0; ir[g] = 1'b0;
      prev_v[g] = 1'b0; prev_hs[g] = 1'b0; prev_a[g] = '0; prev_w[g] = '0; prev_d[g] = '0;
      clear_mon(g);
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready[0]), 32'd1);
    chk("rst_busy",      32'(busy[0]),      32'd0);
    chk("rst_done",      32'(done[0]),      32'd0);
    chk("rst_err",       32'(err[0]),       32'd0);
    chk("rst_valid",     32'(iv[0]),        32'd0);
    chk("rst_wstrb",     32'(wstrb[0]),     32'd0);
    chk("rst_addr",      addr[0],           32'd0);
    chk("rst_wdata",     wdata[0],          32'd0);
    reset = 1'b0;

    // 1: three words, zero-wait responder
    clear_mon(0); dly[0] = 0;
    issue(0, 32'h0300_0000, 32'h0500_0000, 16'd3, k, b1);
    chk("t1_busy_after_accept", 32'(b1), 32'd1);
    chk("t1_done_latency", 32'(k), 32'd13);
    chk("t1_err", 32'(err[0]), 32'd0);
    chk("t1_txn_count", 32'(q0.size()), 32'd6);
    if (q0.size() == 6) begin
      for (int i = 0; i < 3; i++) begin
        a = 32'h0300_0000 + 32'(4 * i);
        chk($sformatf("t1_rd%0d_we", i),   32'(q0[2*i].we), 32'd0);
        chk($sformatf("t1_rd%0d_addr", i), q0[2*i].a, a);
        chk($sformatf("t1_wr%0d_we", i),   32'(q0[2*i+1].we), 32'd1);
        chk($sformatf("t1_wr%0d_addr", i), q0[2*i+1].a, 32'h0500_0000 + 32'(4 * i));
        chk($sformatf("t1_wr%0d_data", i), q0[2*i+1].d, ~a);
      end
    end
    chk("t1_stable", 32'(unstable[0]), 32'd0);
    @(negedge clk);
    chk("t1_done_one_cycle", 32'(done[0]), 32'd0);
    chk("t1_idle_after", 32'(cmd_ready[0]), 32'd1);

    // 2: zero-length command
    clear_mon(0);
    issue(0, 32'h0300_0000, 32'h0500_0000, 16'd0, k, b1);
    chk("t2_done_latency", 32'(k), 32'd1);
    chk("t2_no_valid", 32'(saw_v[0]), 32'd0);

    // 3: fixed source, 5 wait cycles per transaction
    clear_mon(1); dly[1] = 5;
    issue(1, 32'h0200_0010, 32'h0600_0000, 16'd4, k, b1);
    chk("t3_done_latency", 32'(k), 32'd57);
    chk("t3_valid_cycles", 32'(vcyc[1]), 32'd48);
    chk("t3_stable", 32'(unstable[1]), 32'd0);
    chk("t3_txn_count", 32'(q1.size()), 32'd8);
    if (q1.size() == 8) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t3_rd%0d_addr", i), q1[2*i].a, 32'h0200_0010);
        chk($sformatf("t3_wr%0d_addr", i), q1[2*i+1].a, 32'h0600_0000 + 32'(4 * i));
        chk($sformatf("t3_wr%0d_data", i), q1[2*i+1].d, ~32'h0200_0010);
      end
    end

    // 4: destination wraps through zero
    clear_mon(0); dly[0] = 0;
    issue(0, 32'h1000_0000, 32'hFFFF_FFFC, 16'd2, k, b1);
    chk("t4_done_latency", 32'(k), 32'd9);
    chk("t4_txn_count", 32'(q0.size()), 32'd4);
    if (q0.size() == 4) begin
      chk("t4_wr0_addr", q0[1].a, 32'hFFFF_FFFC);
      chk("t4_wr1_addr", q0[3].a, 32'h0000_0000);
      chk("t4_rd1_addr", q0[2].a, 32'h1000_0004);
    end

    // 5: reset while a write is pending
    dly[0] = 3;
    @(negedge clk);
    cmd_src[0] = 32'h0300_0000; cmd_dst[0] = 32'h0500_0000; cmd_len[0] = 16'd2;
    cmd_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (iv[0] && wstrb[0] == 4'hF) found = 1'b1;
      else @(negedge clk);
    end
    chk("t5_reach_wr", 32'(found), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_valid_low", 32'(iv[0]), 32'd0);
    chk("t5_cmd_ready", 32'(cmd_ready[0]), 32'd1);
    chk("t5_busy", 32'(busy[0]), 32'd0);
    chk("t5_done", 32'(done[0]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done[0]) saw_done = 1'b1;
    end
    chk("t5_no_done", 32'(saw_done), 32'd0);

`ifdef IOMEM_TIMEOUT_EN
    // 6: responder never answers
    clear_mon(0); dly[0] = 100000;
    issue(0, 32'h0300_0000, 32'h0500_0000, 16'd3, k, b1);
    chk("t6_done_latency", 32'(k), 32'd9);
    chk("t6_valid_cycles", 32'(vcyc[0]), 32'd8);
    chk("t6_valid_low", 32'(iv[0]), 32'd0);
    chk("t6_err_set", 32'(err[0]), 32'd1);
    dly[0] = 0;
    issue(0, 32'h0300_0000, 32'h0500_0000, 16'd0, k, b1);
    chk("t6_err_cleared", 32'(err[0]), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
